// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and the data memory.
// Signal names are written from the load/store unit's side of the bus.
interface load_store_unit_if;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
      input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
      output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );
endinterface

// File: rtl/load_store_unit.sv
// M-stage load/store unit: checks alignment, issues one data-memory
// request per op, stalls the pipeline until completion or timeout, and
// returns sign/zero-extended load data to the W stage.
module load_store_unit #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic        ld_valid_o,
   output logic [31:0] ld_data_o,
   output logic        misalign_o,
   output logic        timeout_o,
   load_store_unit_if.master dmem
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   // Counter value seen in the last cycle a transaction may stay busy.
   localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

   state_t      r_state;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [1:0]  r_off;
   logic [29:0] r_addr_hi;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [7:0]  r_cnt;
   logic        r_dmem_req;
   logic        r_ld_valid;
   logic [31:0] r_ld_data;
   logic        r_misalign;
   logic        r_timeout;

   logic        w_misalign;
   logic        w_accept;
   logic        w_busy;
   logic        w_done_st;
   logic        w_done_ld;
   logic        w_done;
   logic        w_timeout;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ld_data;

   assign w_misalign = (req_size_i == 2'b11)
                     || ((req_size_i == SZ_HALF) && addr_i[0])
                     || ((req_size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));
   assign w_accept   = (r_state == S_IDLE) && req_valid_i && !w_misalign;
   assign w_busy     = (r_state != S_IDLE);
   // rvalid only counts once the request has been granted.
   assign w_done_st  = (r_state == S_REQ) && dmem.dmem_gnt_i && r_we;
   assign w_done_ld  = ((r_state == S_REQ) && dmem.dmem_gnt_i && !r_we && dmem.dmem_rvalid_i)
                     || ((r_state == S_WAIT) && dmem.dmem_rvalid_i);
   assign w_done     = w_done_st || w_done_ld;
   assign w_timeout  = w_busy && !w_done && (r_cnt == LP_LAST);

   // Upstream advances on the completion or timeout edge, so stall drops then.
   assign stall_o    = w_accept || (w_busy && !w_done && !w_timeout);

   // Byte enables and lane-replicated store data from the incoming request.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      w_be    = 4'b1111;
      w_wdata = wdata_i;
      case (req_size_i)
         SZ_BYTE: begin
            w_be    = 4'b0001 << addr_i[1:0];
            w_wdata = {4{wdata_i[7:0]}};
         end
         SZ_HALF: begin
            w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane select and sign/zero extension of returning load data.
   always_comb begin
      w_byte    = dmem.dmem_rdata_i[8*r_off +: 8];
      w_half    = r_off[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
      w_ld_data = dmem.dmem_rdata_i;
      case (r_size)
         SZ_BYTE: w_ld_data = {{24{!r_unsigned && w_byte[7]}}, w_byte};
         SZ_HALF: w_ld_data = {{16{!r_unsigned && w_half[15]}}, w_half};
         default: ;
      endcase
   end

   // Transaction FSM with registered request, result and exception outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= S_IDLE;
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_off      <= 2'b00;
         r_addr_hi  <= '0;
         r_be       <= 4'b0000;
         r_wdata    <= '0;
         r_cnt      <= '0;
         r_dmem_req <= 1'b0;
         r_ld_valid <= 1'b0;
         r_ld_data  <= '0;
         r_misalign <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_ld_valid <= 1'b0;
         r_misalign <= 1'b0;
         r_timeout  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid_i && w_misalign) begin
                  r_misalign <= 1'b1;
               end else if (w_accept) begin
                  r_we       <= req_we_i;
                  r_size     <= req_size_i;
                  r_unsigned <= req_unsigned_i;
                  r_off      <= addr_i[1:0];
                  r_addr_hi  <= addr_i[31:2];
                  r_be       <= w_be;
                  r_wdata    <= w_wdata;
                  r_cnt      <= '0;
                  r_dmem_req <= 1'b1;
                  r_state    <= S_REQ;
               end
            end
            default: begin
               r_cnt <= r_cnt + 8'd1;
               if (w_done) begin
                  r_dmem_req <= 1'b0;
                  r_state    <= S_IDLE;
                  if (w_done_ld) begin
                     r_ld_data  <= w_ld_data;
                     r_ld_valid <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_dmem_req <= 1'b0;
                  r_timeout  <= 1'b1;
                  r_state    <= S_IDLE;
               end else if ((r_state == S_REQ) && dmem.dmem_gnt_i) begin
                  r_dmem_req <= 1'b0;
                  r_state    <= S_WAIT;
               end
            end
         endcase
      end
   end

   assign dmem.dmem_req_o   = r_dmem_req;
   assign dmem.dmem_we_o    = r_we;
   assign dmem.dmem_be_o    = r_be;
   assign dmem.dmem_addr_o  = {r_addr_hi, 2'b00};
   assign dmem.dmem_wdata_o = r_wdata;
   assign ld_valid_o        = r_ld_valid;
   assign ld_data_o         = r_ld_data;
   assign misalign_o        = r_misalign;
   assign timeout_o         = r_timeout;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MAX_WAIT, default 15, SHALL set the maximum cycles a transaction may spend in REQ plus WAIT before timeout (legal 1..255).
REQ-002 clk_i  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 rst_n_i  input  1  SHALL be the reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  SHALL flag an M-stage memory op; upstream holds all req_* and addr_i/wdata_i stable while stall_o=1.
REQ-005 req_we_i  input  1  SHALL select store (1) or load (0).
REQ-006 req_size_i  input  2  SHALL encode 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 req_unsigned_i  input  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-008 addr_i  input  32  SHALL be the byte address (M-stage ALU result).
REQ-009 wdata_i  input  32  SHALL be store data, right-justified.
REQ-010 stall_o  output  1  SHALL freeze upstream pipeline registers when 1.
REQ-011 ld_valid_o  output  1  SHALL pulse one cycle when ld_data_o holds a new load result.
REQ-012 ld_data_o  output  32  SHALL carry the extended load result to the W-stage mux.
REQ-013 misalign_o, timeout_o  output  1 each  SHALL be one-cycle exception pulses.
REQ-014 dmem_req_o, dmem_we_o  output  1 each; dmem_be_o  output  4; dmem_addr_o, dmem_wdata_o  output  32  SHALL form the data-memory request.
REQ-015 dmem_gnt_i, dmem_rvalid_i  input  1 each; dmem_rdata_i  input  32  SHALL be the memory grant, read-valid and read data.

Function
REQ-016 FSM states IDLE, REQ, WAIT; reset state IDLE.
REQ-017 Misaligned = size 11, or half with addr_i[0]=1, or word with addr_i[1:0]!=0.
REQ-018 In IDLE with req_valid_i=1 and misaligned: misalign_o=1 next cycle, no memory access, stall_o=0, stay IDLE.
REQ-019 In IDLE with req_valid_i=1 and aligned: stall_o=1 combinationally; register we/size/unsigned/addr[1:0], addr_i[31:2], lane data; go REQ; clear wait counter.
REQ-020 In REQ: dmem_req_o=1, dmem_addr_o={addr[31:2],2'b00}, we/be/wdata constant from registers until dmem_gnt_i=1.
REQ-021 REQ with gnt and store: transaction complete, go IDLE.
REQ-022 REQ with gnt and load: go WAIT; if dmem_rvalid_i=1 in the same cycle, complete immediately and go IDLE.
REQ-023 In WAIT: dmem_req_o=0; on dmem_rvalid_i=1 complete and go IDLE.
REQ-024 dmem_rvalid_i SHALL be ignored in IDLE, and in REQ without gnt.
REQ-025 stall_o SHALL be 0 in the completion cycle and the timeout cycle, so upstream advances on that edge, and 1 in every other REQ/WAIT cycle.
REQ-026 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1); word 4'b1111.
REQ-027 Store data: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-028 Load: select byte/half lane by registered addr[1:0]; extend to 32 bits per req_unsigned_i.
REQ-029 Load completion SHALL register ld_data_o and pulse ld_valid_o the following cycle; ld_data_o holds until the next load completes.
REQ-030 Wait counter increments each REQ/WAIT cycle; when it reaches MAX_WAIT without completion: timeout_o=1 next cycle, dmem_req_o dropped, go IDLE, no ld_valid_o.

Reset
REQ-031 While rst_n_i=0, regardless of clock: state IDLE; all outputs 0 except stall_o, which follows REQ-019 combinationally; ld_data_o=0; counter=0.
REQ-032 Reset mid-transaction SHALL drop dmem_req_o immediately; a late rvalid after release SHALL be ignored per REQ-024.

Verification
REQ-033 Word load addr 0x100, gnt cycle 1, rvalid cycle 3, rdata 0xDEADBEEF -> dmem_addr_o 0x100, be 1111, stall 1 until rvalid cycle, ld_valid_o pulse, ld_data_o 0xDEADBEEF.
REQ-034 Signed byte load addr 0x103, rdata 0x80FF_FF7F -> ld_data_o 0xFFFFFF80; same with unsigned -> 0x00000080.
REQ-035 Half store addr 0x22, wdata 0x0000ABCD, gnt held off 3 cycles -> be 1100, dmem_wdata_o 0xABCDABCD stable throughout, dmem_addr_o 0x20, single completion.
REQ-036 Word load addr 0x102 -> misalign_o pulse, dmem_req_o never 1, stall_o 0.
REQ-037 Load with gnt never asserted, MAX_WAIT=15 -> timeout_o pulse after 15 REQ cycles, return IDLE, ld_valid_o 0.
REQ-038 Assert rst_n_i=0 in WAIT, release, then drive rvalid -> dmem_req_o 0 during reset, ld_valid_o stays 0, next request accepted normally.
